// File: rtl/jogo_pkg.sv
// ==== jogo_pkg : state codes and button decode shared by the bot player (rev 1.0) ====
`default_nettype none

package jogo_pkg;

  localparam logic [3:0] S_OCIOSO         = 4'h0;
  localparam logic [3:0] S_INICIA         = 4'h1;
  localparam logic [3:0] S_ESPERA_EXIB    = 4'h2;
  localparam logic [3:0] S_CAPTURA        = 4'h3;
  localparam logic [3:0] S_PREPARA        = 4'h4;
  localparam logic [3:0] S_PRESSIONA      = 4'h5;
  localparam logic [3:0] S_SOLTA          = 4'h6;
  localparam logic [3:0] S_PROXIMA        = 4'h7;
  localparam logic [3:0] S_NOVA           = 4'h8;
  localparam logic [3:0] S_PRESSIONA_NOVA = 4'h9;
  localparam logic [3:0] S_SOLTA_NOVA     = 4'hA;
  localparam logic [3:0] S_AUMENTA        = 4'hB;
  localparam logic [3:0] S_FIM            = 4'hC;

  localparam logic [3:0] ONEHOT_TAB [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  function automatic logic [3:0] decode_onehot(input logic [1:0] sel);
    return ONEHOT_TAB[sel];
  endfunction

  // Deliberate wrong press: neighbouring button, wrapping 1000 -> 0001.
  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jogador_automatico_if.sv
// ==== jogador_automatico_if : bot <-> game signal bundle (rev 1.0) ====
`default_nettype none

interface jogador_automatico_if;
  logic       exibindo;
  logic [3:0] leds;
  logic       pronto;
  logic       acertou;
  logic       iniciar;
  logic [3:0] botoes;

  modport master (input exibindo, leds, pronto, acertou, output iniciar, botoes);
  modport slave  (output exibindo, leds, pronto, acertou, input iniciar, botoes);
endinterface

`default_nettype wire

// File: rtl/jogador_automatico_lfsr8.sv
// ==== lfsr8 : free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (rev 1.0) ====
`default_nettype none

module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  wire logic       clock,
  input  wire logic       reset,
  output logic      [1:0] bits
);

  logic [7:0] q;
  logic       feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];
  assign bits     = q[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= SEED;
    else       q <= {q[6:0], feedback};
  end

endmodule

`default_nettype wire

// File: rtl/jogador_automatico.sv
// ==== jogador_automatico : automatic player that captures and replays the game sequence (rev 1.0) ====
`default_nettype none

module jogador_automatico
  import jogo_pkg::*;
#(
  parameter int T_PRESS = 8,
  parameter int T_GAP   = 8,
  parameter int DEPTH   = 16
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       habilita,
  input  wire logic       injeta_erro,
  input  wire logic [3:0] erro_idx,
  jogador_automatico_if.master jogo,
  output logic            ativo,
  output logic            vitoria,
  output logic      [3:0] limite,
  output logic      [3:0] db_estado
);

  localparam logic [7:0] TIMER_PRESS = 8'(T_PRESS - 1);
  localparam logic [7:0] TIMER_GAP   = 8'(T_GAP - 1);
  localparam logic [3:0] LIMITE_MAX  = 4'(DEPTH - 1);

  logic [3:0] state, next_state;
  logic [3:0] idx, next_idx;
  logic [7:0] timer;
  logic [3:0] press;
  logic [3:0] nova_val;
  logic [1:0] lfsr_bits;
  logic       timer_done;
  logic [3:0] mem [DEPTH];

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .bits  (lfsr_bits)
  );

  assign nova_val   = decode_onehot(lfsr_bits);
  assign timer_done = (timer == 8'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_OCIOSO;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!habilita) begin
      next_state = S_OCIOSO;
    end else if (jogo.pronto && state != S_OCIOSO && state != S_FIM) begin
      next_state = S_FIM;
    end else begin
      case (state)
        S_OCIOSO:         next_state = S_INICIA;
        S_INICIA:         next_state = S_ESPERA_EXIB;
        S_ESPERA_EXIB:    if (jogo.exibindo) next_state = S_CAPTURA;
        S_CAPTURA:        if (!jogo.exibindo) next_state = S_PREPARA;
        S_PREPARA:        next_state = S_PRESSIONA;
        S_PRESSIONA:      if (timer_done) next_state = S_SOLTA;
        S_SOLTA:          if (timer_done) next_state = S_PROXIMA;
        S_PROXIMA:        next_state = (idx == limite) ? S_NOVA : S_PRESSIONA;
        S_NOVA:           next_state = S_PRESSIONA_NOVA;
        S_PRESSIONA_NOVA: if (timer_done) next_state = S_SOLTA_NOVA;
        S_SOLTA_NOVA:     if (timer_done) next_state = S_AUMENTA;
        S_AUMENTA:        next_state = (limite == LIMITE_MAX) ? S_FIM : S_PREPARA;
        S_FIM:            next_state = S_FIM;
        default:          next_state = S_OCIOSO;
      endcase
    end
  end

  // botoes is gated by the state register so an async reset clears it at once.
  always_comb begin
    jogo.iniciar = (state == S_INICIA);
    jogo.botoes  = (state == S_PRESSIONA || state == S_PRESSIONA_NOVA) ? press : 4'b0000;
    ativo        = (state != S_OCIOSO) && (state != S_FIM);
    db_estado    = state;
  end

  always_comb begin
    next_idx = idx;
    if (state == S_PREPARA)                     next_idx = 4'd0;
    else if (state == S_PROXIMA && idx != limite) next_idx = idx + 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx     <= 4'd0;
      limite  <= 4'd0;
      timer   <= 8'd0;
      vitoria <= 1'b0;
      press   <= 4'b0000;
    end else begin
      idx <= next_idx;

      if (next_state != state) begin
        case (next_state)
          S_PRESSIONA, S_PRESSIONA_NOVA: timer <= TIMER_PRESS;
          S_SOLTA, S_SOLTA_NOVA:         timer <= TIMER_GAP;
          default:                       timer <= 8'd0;
        endcase
      end else if (!timer_done) begin
        timer <= timer - 8'd1;
      end

      if (next_state == S_PRESSIONA && state != S_PRESSIONA)
        press <= (injeta_erro && next_idx == erro_idx) ? rotl1(mem[next_idx]) : mem[next_idx];
      else if (state == S_NOVA)
        press <= nova_val;

      if (state == S_INICIA || state == S_CAPTURA)
        limite <= 4'd0;
      else if (state == S_AUMENTA && next_state == S_PREPARA)
        limite <= limite + 4'd1;

      if (state == S_INICIA)
        vitoria <= 1'b0;
      else if (next_state == S_FIM && state != S_FIM)
        vitoria <= jogo.acertou;
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_CAPTURA && jogo.leds != 4'b0000)
      mem[0] <= jogo.leds;
    if (state == S_NOVA)
      mem[limite + 4'd1] <= nova_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_jogador_automatico.sv
// ==== tb_jogador_automatico : scoreboard bench for the bot player (rev 1.0) ====
`default_nettype none

module tb_jogador_automatico;

  localparam int T_PRESS = 8;
  localparam int T_GAP   = 8;
  localparam int DEPTH   = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic       injeta_erro;
  logic [3:0] erro_idx;
  logic       ativo, vitoria;
  logic [3:0] limite, db_estado;

  jogador_automatico_if gif ();

  jogador_automatico #(.T_PRESS(T_PRESS), .T_GAP(T_GAP), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .injeta_erro (injeta_erro),
    .erro_idx    (erro_idx),
    .jogo        (gif),
    .ativo       (ativo),
    .vitoria     (vitoria),
    .limite      (limite),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [3:0] q_exp [$];
  logic [3:0] model_mem [DEPTH];
  int         model_lim = 0;
  logic [7:0] model_lfsr;
  logic       abort_flag = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  // Reference LFSR from the tap polynomial, seed A5.
  always @(posedge clock or posedge reset) begin
    if (reset) model_lfsr <= 8'hA5;
    else       model_lfsr <= {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
  end

  // Expectation generator: pushes the presses each phase should produce.
  logic [3:0] prev_state = 4'h0;
  always @(negedge clock) begin
    if (reset) begin
      prev_state = 4'h0;
    end else if (db_estado != prev_state) begin
      case (db_estado)
        4'h3: model_lim = 0;
        4'h4: for (int i = 0; i <= model_lim; i++)
                q_exp.push_back((injeta_erro && i == int'(erro_idx)) ?
                                {model_mem[i][2:0], model_mem[i][3]} : model_mem[i]);
        4'h8: begin
                model_mem[model_lim + 1] = onehot(model_lfsr[1:0]);
                q_exp.push_back(onehot(model_lfsr[1:0]));
              end
        4'hB: if (model_lim < DEPTH - 1) model_lim++;
        default: ;
      endcase
      prev_state = db_estado;
    end
  end

  // Monitor: pops on every new press, checks value, hold length and gap.
  int         hi_cnt = 0, lo_cnt = 0;
  logic       seen_press = 1'b0;
  logic [3:0] cur_press = 4'b0;
  always @(negedge clock) begin
    if (reset) begin
      hi_cnt = 0; lo_cnt = 0; seen_press = 1'b0;
    end else if (gif.botoes != 4'b0000) begin
      if (hi_cnt == 0) begin
        if (seen_press) begin
          checks++;
          if (lo_cnt < T_GAP) begin
            errors++;
            $display("FAIL press_gap: got %0d zero cycles, need at least %0d", lo_cnt, T_GAP);
          end
        end
        checks++;
        if (q_exp.size() == 0) begin
          errors++;
          $display("FAIL press_unexpected: got %b with empty scoreboard", gif.botoes);
        end else begin
          logic [3:0] e;
          e = q_exp.pop_front();
          if (gif.botoes !== e) begin
            errors++;
            $display("FAIL press_value: got %b expected %b", gif.botoes, e);
          end
        end
        chk("press_onehot", 8'($onehot(gif.botoes)), 8'd1);
        cur_press = gif.botoes;
      end else if (gif.botoes != cur_press) begin
        chk("press_changed", {4'h0, gif.botoes}, {4'h0, cur_press});
      end
      hi_cnt++;
      lo_cnt = 0;
      seen_press = 1'b1;
    end else begin
      if (hi_cnt != 0) begin
        if (!abort_flag) chk("press_len", 8'(hi_cnt), 8'(T_PRESS));
        abort_flag = 1'b0;
      end
      hi_cnt = 0;
      lo_cnt++;
    end
  end

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (db_estado !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_state", {4'h0, db_estado}, {4'h0, s});
  endtask

  task automatic show(input logic [3:0] v, input int cycles);
    gif.exibindo = 1'b1;
    gif.leds     = v;
    model_mem[0] = v;
    repeat (cycles) @(negedge clock);
    gif.exibindo = 1'b0;
    gif.leds     = 4'b0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_iniciar"}, {7'h0, gif.iniciar}, 8'h00);
    chk({tag, "_botoes"},  {4'h0, gif.botoes}, 8'h00);
    chk({tag, "_ativo"},   {7'h0, ativo}, 8'h00);
    chk({tag, "_vitoria"}, {7'h0, vitoria}, 8'h00);
    chk({tag, "_limite"},  {4'h0, limite}, 8'h00);
    chk({tag, "_estado"},  {4'h0, db_estado}, 8'h00);
    chk({tag, "_lfsr"},    dut.u_lfsr.q, 8'hA5);
  endtask

  initial begin
    int n;
    reset = 1'b1; habilita = 1'b0; injeta_erro = 1'b0; erro_idx = 4'd0;
    gif.exibindo = 1'b0; gif.leds = 4'b0000; gif.pronto = 1'b0; gif.acertou = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Start pulse and first states.
    habilita = 1'b1;
    @(negedge clock);
    chk("start_estado1", {4'h0, db_estado}, 8'h01);
    chk("start_iniciar1", {7'h0, gif.iniciar}, 8'h01);
    chk("start_ativo", {7'h0, ativo}, 8'h01);
    @(negedge clock);
    chk("start_estado2", {4'h0, db_estado}, 8'h02);
    chk("start_iniciar2", {7'h0, gif.iniciar}, 8'h00);

    // Capture 0100 and play three full rounds.
    show(4'b0100, 20);
    n = 0;
    while (limite != 4'd3 && n < 3000) begin @(negedge clock); n++; end
    chk("rounds_limite", {4'h0, limite}, 8'h03);

    // Abort in the middle of a replay press.
    n = 0;
    while (!(db_estado == 4'h5 && gif.botoes != 4'b0) && n < 200) begin @(negedge clock); n++; end
    chk("abort_in_press", {4'h0, db_estado}, 8'h05);
    abort_flag = 1'b1;
    habilita = 1'b0;
    @(negedge clock);
    chk("abort_botoes", {4'h0, gif.botoes}, 8'h00);
    chk("abort_estado", {4'h0, db_estado}, 8'h00);
    q_exp.delete();

    // Wrong press on index 0, then game reports loss.
    injeta_erro = 1'b1; erro_idx = 4'd0;
    @(negedge clock);
    habilita = 1'b1;
    wait_state(4'h2, 10);
    show(4'b1000, 5);
    n = 0;
    while (gif.botoes == 4'b0 && n < 50) begin @(negedge clock); n++; end
    chk("erro_press", {4'h0, gif.botoes}, 8'h01);
    abort_flag = 1'b1;
    gif.pronto = 1'b1; gif.acertou = 1'b0;
    @(negedge clock);
    chk("erro_fim", {4'h0, db_estado}, 8'h0C);
    chk("erro_vitoria", {7'h0, vitoria}, 8'h00);
    chk("erro_botoes", {4'h0, gif.botoes}, 8'h00);
    chk("erro_ativo", {7'h0, ativo}, 8'h00);
    gif.pronto = 1'b0; injeta_erro = 1'b0;
    habilita = 1'b0;
    @(negedge clock);
    chk("fim_to_ocioso", {4'h0, db_estado}, 8'h00);
    q_exp.delete();

    // Win reported while waiting for the display.
    habilita = 1'b1;
    wait_state(4'h2, 10);
    gif.pronto = 1'b1; gif.acertou = 1'b1;
    @(negedge clock);
    chk("win_fim", {4'h0, db_estado}, 8'h0C);
    chk("win_vitoria", {7'h0, vitoria}, 8'h01);
    gif.pronto = 1'b0; gif.acertou = 1'b0;
    habilita = 1'b0;
    @(negedge clock);
    chk("win_hold_vitoria", {7'h0, vitoria}, 8'h01);

    // Async reset during SOLTA_NOVA.
    habilita = 1'b1;
    wait_state(4'h2, 10);
    show(4'b0001, 3);
    wait_state(4'hA, 200);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async");
    habilita = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    q_exp.delete();
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
